piso_left: RTL and testbench

Parallel-in serial-out shift register. This is the transmit end of the codebase's left-shifting serial link.
- Accepts one INPUT_WIDTH-bit word through a valid/ready handshake.
- Shifts the word out MSB-first, one bit per clk.
- A shift-left SIPO receiver sampling serial_out on the same clk reassembles the word bit-exact.
- Marks the final bit period so the receiver side can latch.

---
 rtl/piso_left.sv | 93 +++++++++
 tb/tb_piso_left.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_left.sv
// piso_left: parallel-in serial-out transmitter for the left-shifting serial link.
// A word is accepted through a valid/ready handshake (load/ready) and shifted
// out MSB-first, one bit per clk. `last` marks the final bit period of each
// frame so a matching shift-left receiver knows when to latch the word.
//
// Optional feature: define PISO_PARITY_EN to append one even-parity bit period
// after the LSB (frame length INPUT_WIDTH+1).
//
// Parameters:
//   INPUT_WIDTH  width of the parallel word (>= 2)
//   VALUE_PULL   idle level on serial_out; also the fill bit shifted into the LSB
//
// Ports:
//   clk         clock, rising-edge active
//   reset_n     asynchronous active-low reset
//   load        word valid, sampled on rising clk
//   data        parallel word, captured when load && ready
//   ready       block can accept a word this cycle (from registers only)
//   serial_out  serial data, MSB first
//   busy        frame in progress
//   last        high during the final bit period of a frame
module piso_left #(
  parameter int   INPUT_WIDTH = 8,
  parameter logic VALUE_PULL  = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [INPUT_WIDTH-1:0] data,
  output logic                   ready,
  output logic                   serial_out,
  output logic                   busy,
  output logic                   last
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = INPUT_WIDTH + 1;
`else
  localparam int FRAME_LEN = INPUT_WIDTH;
`endif
  localparam int CNT_W = $clog2(INPUT_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]           state;
  logic [FRAME_LEN-1:0] shreg;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 accept;

  // Frame image loaded at accept: the word, with the parity bit tucked below
  // the LSB when parity is enabled so it simply falls out after the data.
  function automatic logic [FRAME_LEN-1:0] frame_word(input logic [INPUT_WIDTH-1:0] d);
`ifdef PISO_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  function automatic logic [FRAME_LEN-1:0] shift_word(input logic [FRAME_LEN-1:0] s);
    return {s[FRAME_LEN-2:0], VALUE_PULL};
  endfunction

  assign busy       = (state == S_SHIFT);
  assign last       = busy && (bit_cnt == CNT_LAST);
  // Accepting during the final bit period gives gap-free back-to-back frames.
  assign ready      = !busy || last;
  assign serial_out = busy ? shreg[FRAME_LEN-1] : VALUE_PULL;
  assign accept     = load && ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      state   <= S_SHIFT;
      shreg   <= frame_word(data);
      bit_cnt <= '0;
    end else if (state == S_SHIFT) begin
      shreg <= shift_word(shreg);
      if (bit_cnt == CNT_LAST) begin
        state   <= S_IDLE;
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_left.sv
module tb_piso_left;
  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic load = 1'b0;
  logic [W-1:0] data = '0;
  logic ready, serial_out, busy, last;

  logic load1 = 1'b0;
  logic [W-1:0] data1 = '0;
  logic ready1, so1, busy1, last1;

  int n_err = 0;
  int n_checks = 0;
  logic mon_en = 1'b0;

  // expected entries: {bit, is_last}
  logic [1:0] exp_q[$];
  logic [1:0] exp1_q[$];
  logic [W-1:0] sent_q[$];

  always #5 clk = ~clk;

  piso_left #(.INPUT_WIDTH(W), .VALUE_PULL(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .load(load), .data(data),
    .ready(ready), .serial_out(serial_out), .busy(busy), .last(last));

  piso_left #(.INPUT_WIDTH(W), .VALUE_PULL(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .load(load1), .data(data1),
    .ready(ready1), .serial_out(so1), .busy(busy1), .last(last1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Hand-built expected frame: bits MSB first, optional even parity, last flag on final bit.
  task automatic push_frame(input int which, input logic [W-1:0] d);
    logic [1:0] e;
    for (int i = W - 1; i >= 0; i--) begin
      e = {d[i], (N == W) && (i == 0)};
      if (which == 0) exp_q.push_back(e); else exp1_q.push_back(e);
    end
`ifdef PISO_PARITY_EN
    e = {^d, 1'b1};
    if (which == 0) exp_q.push_back(e); else exp1_q.push_back(e);
`endif
    if (which == 0) sent_q.push_back(d);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ready) chk("ready_timeout", {31'b0, ready}, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) chk("idle_timeout", {31'b0, busy}, 0);
  endtask

  task automatic send(input logic [W-1:0] d);
    wait_ready();
    load = 1'b1;
    data = d;
    push_frame(0, d);
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Monitor for dut0: pops one expected bit per busy cycle.
  logic [1:0] e0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bit", {29'b0, busy, serial_out, last}, 0);
        end else begin
          e0 = exp_q.pop_front();
          chk("frame_bit", {29'b0, serial_out, last, ready}, {29'b0, e0[1], e0[0], e0[0]});
        end
      end else begin
        chk("idle0", {29'b0, serial_out, last, ready}, {29'b0, 1'b0, 1'b0, 1'b1});
      end
    end
  end

  // Monitor for dut1 (idle level 1).
  logic [1:0] e1;
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy1) begin
        if (exp1_q.size() == 0) begin
          chk("unexpected_bit1", {30'b0, busy1, so1}, 0);
        end else begin
          e1 = exp1_q.pop_front();
          chk("frame_bit1", {29'b0, so1, last1, ready1}, {29'b0, e1[1], e1[0], e1[0]});
        end
      end else begin
        chk("idle1", {29'b0, so1, last1, ready1}, {29'b0, 1'b1, 1'b0, 1'b1});
      end
    end
  end

  // Shift-left receiver model; latches the word one cycle after last.
  logic [N-1:0] rx_sr;
  logic rx_last_d = 1'b0;
  logic [W-1:0] rx_exp;
  always @(negedge clk) begin
    rx_sr <= {rx_sr[N-2:0], serial_out};
    rx_last_d <= last;
    if (mon_en && rx_last_d) begin
      if (sent_q.size() == 0) begin
        chk("rx_unexpected", {24'b0, rx_sr[N-1 -: W]}, 32'hFFFF_FFFF);
      end else begin
        rx_exp = sent_q.pop_front();
        chk("loopback", {24'b0, rx_sr[N-1 -: W]}, {24'b0, rx_exp});
`ifdef PISO_PARITY_EN
        chk("rx_parity", {31'b0, rx_sr[0]}, {31'b0, ^rx_exp});
`endif
      end
    end
  end

  initial begin
    logic [W-1:0] rnd;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_ready", {31'b0, ready}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_last", {31'b0, last}, 0);
    chk("rst_so", {31'b0, serial_out}, 0);
    chk("rst_so1", {31'b0, so1}, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Basic frame
    send(8'hA5);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back frames
    send(8'h81);
    send(8'h7E);
    chk("b2b_nogap", {30'b0, busy, last}, {30'b0, 1'b1, 1'b0});
    wait_idle();
    @(posedge clk); #1;

    // Load while busy is ignored
    send(8'h00);
    for (int k = 0; k < 7; k++) begin
      chk("ready_low", {31'b0, ready}, 0);
      if (k == 2) begin load = 1'b1; data = 8'hFF; end
      else load = 1'b0;
      @(posedge clk); #1;
    end
    load = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("busy_no_ff", {31'b0, busy}, 0);

    // Reset mid-frame
    send(8'hC3);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_busy", {31'b0, busy}, 0);
    chk("mr_last", {31'b0, last}, 0);
    chk("mr_ready", {31'b0, ready}, 1);
    chk("mr_so", {31'b0, serial_out}, 0);
    chk("mr_cnt", {28'b0, dut0.bit_cnt}, 0);
    exp_q.delete();
    sent_q.delete();
    load = 1'b1; data = 8'hFF;
    @(posedge clk); #1;
    chk("rst_load_ign", {31'b0, busy}, 0);
    load = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    send(8'hC3);
    wait_idle();

    // Idle level 1 on dut1, then a zero word
    repeat (20) @(posedge clk);
    #1;
    load1 = 1'b1; data1 = 8'h00;
    push_frame(1, 8'h00);
    @(posedge clk); #1;
    load1 = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Parity vector (plain 8-bit frame when parity is off)
    send(8'h07);
    wait_idle();

    // Loopback with random words, back-to-back
    for (int i = 0; i < 256; i++) begin
      rnd = W'($urandom);
      send(rnd);
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("drain_exp", exp_q.size() + exp1_q.size(), 0);
    chk("drain_rx", sent_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "timeout");
  end
endmodule
